// File: rtl/wall_clock_pkg.sv
// Shared encodings for the wall-clock time-set path: command opcodes, button FSM
// states and the pending-slot identifiers used by the arbiter.
package wall_clock_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_INC_MIN = 2'd1,
        OP_INC_HR  = 2'd2
    } cmd_op_t;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_HOLD   = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_t;

    // Pending slots, listed in arbitration priority order (carry wins).
    typedef enum logic [1:0] {
        SLOT_CARRY = 2'd0,
        SLOT_MIN   = 2'd1,
        SLOT_HR    = 2'd2
    } slot_t;

    localparam int SEC_MAX = 59;

    function automatic cmd_op_t slot_op(input slot_t s);
        return (s == SLOT_HR) ? OP_INC_HR : OP_INC_MIN;
    endfunction

endpackage

// File: rtl/button_repeat.sv
// Press-and-hold auto-repeat for one debounced button: one request on press,
// one after HOLD_DELAY cycles, then one every REPEAT_PERIOD cycles while held.
module button_repeat
    import wall_clock_pkg::*;
#(
    parameter int HOLD_DELAY    = 50000000,
    parameter int REPEAT_PERIOD = 20000000
) (
    input  logic CLK100MHZ,
    input  logic Reset,
    input  logic level,
    output logic post
);

    localparam int TMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    btn_state_t    state, state_next;
    logic [TW-1:0] timer, timer_next;

    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            state <= BTN_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Releasing the button always aborts silently, whatever phase it was in.
    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        post       = 1'b0;
        if (!level) begin
            state_next = BTN_IDLE;
            timer_next = '0;
        end else begin
            case (state)
                BTN_IDLE: begin
                    post       = 1'b1;
                    state_next = BTN_HOLD;
                    timer_next = '0;
                end
                BTN_HOLD: begin
                    if (timer == TW'(HOLD_DELAY - 1)) begin
                        post       = 1'b1;
                        state_next = BTN_REPEAT;
                        timer_next = '0;
                    end
                end
                BTN_REPEAT: begin
                    if (timer == TW'(REPEAT_PERIOD - 1)) begin
                        post       = 1'b1;
                        timer_next = '0;
                    end
                end
                default: begin
                    state_next = BTN_IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Seconds timebase plus arbiter that serialises seconds carries and button
// increments onto a single valid/ready command port for the hours/minutes block.
module time_set_controller
    import wall_clock_pkg::*;
#(
    parameter int SPEED         = 800000,
    parameter int HOLD_DELAY    = 50000000,
    parameter int REPEAT_PERIOD = 20000000
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic       MButton,
    input  logic       HButton,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [5:0] SecDispl,
    output logic       sec_tick,
    output logic       req_drop
);

    localparam int PW = $clog2(SPEED + 1);

    logic [PW-1:0] presc;
    logic          min_post, hr_post, carry_post;
    logic          handshake, can_select, sel_found, drop_any;
    logic [2:0]    pend, pend_next, post_vec, consume, avail;
    slot_t         cur_slot, sel_slot;

    button_repeat #(.HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mbtn (
        .CLK100MHZ(CLK100MHZ),
        .Reset    (Reset),
        .level    (MButton),
        .post     (min_post)
    );

    button_repeat #(.HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_hbtn (
        .CLK100MHZ(CLK100MHZ),
        .Reset    (Reset),
        .level    (HButton),
        .post     (hr_post)
    );

    assign carry_post = sec_tick && (SecDispl == 6'(SEC_MAX));
    assign handshake  = cmd_valid && cmd_ready;
    assign can_select = !cmd_valid || handshake;

    // Seconds run free of the command port so a stalled datapath never slows time.
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            SecDispl <= '0;
        end else begin
            if (presc == PW'(SPEED - 1)) begin
                presc    <= '0;
                sec_tick <= 1'b1;
            end else begin
                presc    <= presc + 1'b1;
                sec_tick <= 1'b0;
            end
            if (sec_tick) begin
                SecDispl <= (SecDispl == 6'(SEC_MAX)) ? '0 : SecDispl + 1'b1;
            end
        end
    end

    // A slot being handed off this cycle is free again, so a fresh post refills it
    // instead of being dropped; it is not eligible for selection until next cycle.
    always_comb begin
        post_vec   = {hr_post, min_post, carry_post};
        consume    = '0;
        consume[0] = handshake && (cur_slot == SLOT_CARRY);
        consume[1] = handshake && (cur_slot == SLOT_MIN);
        consume[2] = handshake && (cur_slot == SLOT_HR);
        avail      = pend & ~consume;
        drop_any   = |(post_vec & avail);
        pend_next  = avail | post_vec;
        sel_found  = |avail;
        sel_slot   = SLOT_CARRY;
        if (avail[0]) begin
            sel_slot = SLOT_CARRY;
        end else if (avail[1]) begin
            sel_slot = SLOT_MIN;
        end else if (avail[2]) begin
            sel_slot = SLOT_HR;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            pend      <= '0;
            req_drop  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NONE;
            cur_slot  <= SLOT_CARRY;
        end else begin
            pend     <= pend_next;
            req_drop <= drop_any;
            if (can_select) begin
                cmd_valid <= sel_found;
                cmd_op    <= sel_found ? slot_op(sel_slot) : OP_NONE;
                cur_slot  <= sel_slot;
            end
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Randomised and directed bench for time_set_controller: a timing model predicts
// commands into a scoreboard queue that a negedge monitor drains and checks.
module tb_time_set_controller;
    import wall_clock_pkg::*;

    localparam int SPEED         = 10;
    localparam int HOLD_DELAY    = 20;
    localparam int REPEAT_PERIOD = 5;

    logic       CLK100MHZ = 1'b0;
    logic       Reset     = 1'b0;
    logic       MButton   = 1'b0;
    logic       HButton   = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [5:0] SecDispl;
    logic       sec_tick;
    logic       req_drop;

    int n_checks = 0;
    int n_fail   = 0;

    time_set_controller #(
        .SPEED(SPEED), .HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_dut (
        .CLK100MHZ(CLK100MHZ),
        .Reset    (Reset),
        .MButton  (MButton),
        .HButton  (HButton),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .SecDispl (SecDispl),
        .sec_tick (sec_tick),
        .req_drop (req_drop)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic mb, input logic hb, input logic rdy, input int n);
        MButton   = mb;
        HButton   = hb;
        cmd_ready = rdy;
        repeat (n) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    // Reference model: time and button requests come from edge counts, pending
    // requests live in three one-deep boxes served lowest index first.
    int m_edge = 0, m_mheld = 0, m_hheld = 0, m_slot = 0, m_pick = 0, m_incs = 0;
    bit m_pend[3], m_posts[3], m_avail[3];
    bit m_valid = 0, m_hs = 0;
    int exp_sec = 0, exp_tick = 0, exp_drop = 0;
    int exp_q[$];

    function automatic bit held_post(input int n);
        if (n == 1) return 1'b1;
        if (n < HOLD_DELAY + 1) return 1'b0;
        return ((n - 1 - HOLD_DELAY) % REPEAT_PERIOD) == 0;
    endfunction

    always @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            m_edge = 0; m_mheld = 0; m_hheld = 0; m_slot = 0;
            m_pend = '{default: 1'b0};
            m_valid = 1'b0;
            exp_sec = 0; exp_tick = 0; exp_drop = 0;
            exp_q.delete();
        end else begin
            m_edge++;
            m_incs     = (m_edge - 1) / SPEED;
            m_posts[0] = (m_edge > 1) && ((m_edge - 1) % SPEED == 0) && (m_incs % 60 == 0);
            m_mheld    = MButton ? m_mheld + 1 : 0;
            m_hheld    = HButton ? m_hheld + 1 : 0;
            m_posts[1] = MButton && held_post(m_mheld);
            m_posts[2] = HButton && held_post(m_hheld);
            m_hs       = m_valid && cmd_ready;
            exp_drop   = 0;
            m_pick     = -1;
            for (int i = 0; i < 3; i++) m_avail[i] = m_pend[i] && !(m_hs && m_slot == i);
            for (int i = 2; i >= 0; i--) if (m_avail[i]) m_pick = i;
            for (int i = 0; i < 3; i++) begin
                if (m_posts[i] && m_avail[i]) exp_drop = 1;
                m_pend[i] = m_avail[i] || m_posts[i];
            end
            if (!m_valid || m_hs) begin
                m_valid = (m_pick >= 0);
                if (m_pick >= 0) begin
                    m_slot = m_pick;
                    exp_q.push_back((m_pick == 2) ? 2 : 1);
                end
            end
            exp_tick = (m_edge % SPEED == 0) ? 1 : 0;
            exp_sec  = m_incs % 60;
        end
    end

    // Monitor: compares every cycle and retires a scoreboard entry on each handshake.
    int n_tick = 0, n_wrap = 0, n_min = 0, n_hr = 0, n_drop = 0, prev_sec = 0;
    int hr_edges[$];

    always @(negedge CLK100MHZ) begin
        checkOutput("sec_displ", SecDispl, exp_sec);
        checkOutput("sec_tick", sec_tick, exp_tick);
        checkOutput("req_drop", req_drop, exp_drop);
        checkOutput("cmd_valid", cmd_valid, m_valid);
        if (cmd_valid) begin
            checkOutput("cmd_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                checkOutput("cmd_op", cmd_op, exp_q[0]);
                if (cmd_ready) void'(exp_q.pop_front());
            end
            if (cmd_ready && cmd_op == OP_INC_MIN) n_min++;
            if (cmd_ready && cmd_op == OP_INC_HR) begin
                n_hr++;
                hr_edges.push_back(m_edge);
            end
        end else begin
            checkOutput("cmd_op_idle", cmd_op, OP_NONE);
        end
        n_tick += sec_tick;
        n_drop += req_drop;
        if (prev_sec == SEC_MAX && SecDispl == 0) n_wrap++;
        prev_sec = SecDispl;
    end

    initial begin
        int s_min, s_hr, s_drop, s_tick, s_wrap, s_hq;
        logic mb, hb, rdy;

        applyStimulus(0, 0, 1, 3);
        Reset = 1'b1;

        // Free-running minute: one carry after sixty seconds.
        s_tick = n_tick; s_wrap = n_wrap; s_min = n_min; s_hr = n_hr; s_drop = n_drop;
        applyStimulus(0, 0, 1, 605);
        checkOutput("p1_ticks", n_tick - s_tick, 60);
        checkOutput("p1_wraps", n_wrap - s_wrap, 1);
        checkOutput("p1_inc_min", n_min - s_min, 1);
        checkOutput("p1_inc_hr", n_hr - s_hr, 0);
        checkOutput("p1_drops", n_drop - s_drop, 0);

        // Short minute press.
        s_min = n_min; s_hr = n_hr;
        applyStimulus(1, 0, 1, 3);
        applyStimulus(0, 0, 1, 12);
        checkOutput("p2_inc_min", n_min - s_min, 1);
        checkOutput("p2_inc_hr", n_hr - s_hr, 0);
        checkOutput("p2_mbtn_idle", u_dut.u_mbtn.state, BTN_IDLE);

        // Hour held long enough to auto-repeat.
        s_hr = n_hr; s_hq = hr_edges.size();
        applyStimulus(0, 1, 1, 40);
        applyStimulus(0, 0, 1, 5);
        checkOutput("p3_inc_hr", n_hr - s_hr, 5);
        if (hr_edges.size() >= s_hq + 5) begin
            checkOutput("p3_gap_hold", hr_edges[s_hq + 1] - hr_edges[s_hq], HOLD_DELAY);
            for (int i = 2; i < 5; i++)
                checkOutput("p3_gap_repeat", hr_edges[s_hq + i] - hr_edges[s_hq + i - 1], REPEAT_PERIOD);
        end

        // Minute press landing on the seconds wrap with the port stalled.
        while (m_edge < 1200) applyStimulus(0, 0, 0, 1);
        s_min = n_min; s_drop = n_drop;
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 6);
        checkOutput("p4_stall_valid", cmd_valid, 1);
        checkOutput("p4_stall_op", cmd_op, OP_INC_MIN);
        applyStimulus(0, 0, 1, 6);
        checkOutput("p4_inc_min", n_min - s_min, 2);
        checkOutput("p4_drops", n_drop - s_drop, 0);

        // Second press while the first is still pending is dropped.
        s_min = n_min; s_drop = n_drop;
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 0, 0, 3);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 0, 0, 3);
        checkOutput("p5_drops", n_drop - s_drop, 1);
        applyStimulus(0, 0, 1, 5);
        checkOutput("p5_inc_min", n_min - s_min, 1);

        // Reset while a command is stalled and the hour button is repeating.
        applyStimulus(0, 1, 0, 30);
        checkOutput("p6_hbtn_repeat", u_dut.u_hbtn.state, BTN_REPEAT);
        checkOutput("p6_pre_valid", cmd_valid, 1);
        Reset = 1'b0;
        #1;
        checkOutput("p6_rst_valid", cmd_valid, 0);
        checkOutput("p6_rst_op", cmd_op, OP_NONE);
        checkOutput("p6_rst_sec", SecDispl, 0);
        checkOutput("p6_rst_tick", sec_tick, 0);
        checkOutput("p6_rst_drop", req_drop, 0);
        applyStimulus(0, 0, 1, 3);
        s_min = n_min; s_hr = n_hr;
        Reset = 1'b1;
        applyStimulus(0, 0, 1, 20);
        checkOutput("p6_no_stale_min", n_min - s_min, 0);
        checkOutput("p6_no_stale_hr", n_hr - s_hr, 0);

        // Random buttons and back-pressure against the model.
        mb = 1'b0; hb = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) mb = ~mb;
            if ($urandom_range(29) == 0) hb = ~hb;
            rdy = ($urandom_range(9) < 7);
            applyStimulus(mb, hb, rdy, 1);
        end
        applyStimulus(0, 0, 1, 10);
        checkOutput("final_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
